datapath_unit: RTL and testbench
================================

Name: datapath_unit

Overview:
- Execution datapath driven by the instruction-fetch controller's decoded control fields.
- Holds a 4 x 8-bit register file, an 8-op ALU, a read-only lookup memory and a registered NZCV flag register.
- Returns ALUFlags to the controller FSM for branch decisions.
- One instruction executes per clock. Writeback and flag update both occur on that instruction's closing clock edge.

Parameters:
- DATA_W, 8, datapath and register width.
- LUT_DEPTH, 256, number of entries in the read-only lookup memory, addressed by ALU result.
- LUT_FILE, "lut_init.hex", hex init file for the lookup memory. Missing entries read 0.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- WE  in  1  register-file write enable for the current instruction.
- ALUorM  in  1  writeback select: 0 = ALU result, 1 = lookup memory read.
- ALUCntr  in  3  ALU operation code.
- ALUSrc2  in  1  operand-B select: 1 = immediate Src2, 0 = register addressed by Src2[1:0].
- RDst3  in  2  destination register index.
- RSrc1  in  2  operand-A register index.
- Src2  in  8  immediate value, or register index in bits [1:0].
- ViewSel  in  2  debug read index.
- ALUFlags  out  4  registered {N,Z,C,V}.
- Result  out  8  combinational writeback value of the current instruction.
- RegView  out  8  combinational contents of register[ViewSel].

Behaviour:
- Reset, applied synchronously on a clk edge with reset=1:
  - R0..R3 = 0 and ALUFlags = 4'b0000.
  - Register writes and flag updates are suppressed in any cycle where reset=1, including reset asserted mid-program.
  - Result and RegView remain combinational and reflect the cleared state after the edge.
- Operands:
  - A = R[RSrc1].
  - B = Src2 when ALUSrc2=1, otherwise R[Src2[1:0]]. Src2[7:2] are ignored in that case.
- ALUCntr encoding, all results truncated to 8 bits:
  - 000 ADD A+B.
  - 001 SUB A-B.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 LSL A by B[2:0].
  - 110 LSR A by B[2:0], zero fill.
  - 111 MOV B.
- Flags, computed from the ALU result. The lookup value never affects flags.
  - N = res[7].
  - Z = (res == 0).
  - ADD: C = carry out of bit 7; V = (A[7]==B[7]) && (res[7]!=A[7]).
  - SUB: C = 1 when A >= B unsigned (no borrow); V = (A[7]!=B[7]) && (res[7]!=A[7]).
  - LSL: C = last bit shifted out, which is A[8-sh] for sh = 1..7. C = 0 when sh = 0. V = 0.
  - LSR: C = A[sh-1] for sh = 1..7. C = 0 when sh = 0. V = 0.
  - AND/OR/XOR/MOV: C = 0, V = 0.
- Flag timing:
  - The flag register updates on every non-reset clock edge, independent of WE, so compare-style instructions with WE=0 still set flags.
  - ALUFlags therefore shows the flags of the previous instruction, one cycle of latency.
- Writeback:
  - Result = LUT[ALU result] when ALUorM=1, else the ALU result.
  - With LUT_DEPTH < 256, addresses at or above depth read 0.
  - On a clock edge with WE=1 and reset=0: R[RDst3] <= Result.
- Register file:
  - Reads are combinational.
  - Same-cycle read of the register being written returns the old value; the new value is visible the next cycle.
  - No bypass is needed because writes complete at the edge.
- Simultaneous events:
  - RDst3 equal to RSrc1 is legal, read-modify-write in one cycle, e.g. R1 <= R1+1.
  - reset has priority over WE.
- No X propagation: every output is defined for every input combination.

Test Plan:
- Reset, then ViewSel sweep 0..3 -> RegView = 0x00 for all registers and ALUFlags = 4'b0000.
- MOV imm: ALUCntr=111, ALUSrc2=1, Src2=0x7F, RDst3=1, WE=1. Then ADD R1 + imm 0x01 into R2 -> R2 = 0x80 and, the cycle after the ADD, ALUFlags = {N=1,Z=0,C=0,V=1}.
- SUB compare with WE=0: R1 = 0x05, B = imm 0x05 -> no register changes and next-cycle ALUFlags = {0,1,1,0}. Then B = 0x06 -> next-cycle flags {1,0,0,0}.
- ADD carry: R0 = 0xFF plus imm 0x01 into R0 -> R0 = 0x00 and flags {0,1,1,0}.
- LSL: R3 = 0x81, shift by 1 -> 0x02, C = 1. LSR of 0x81 by 1 -> 0x40, C = 1. LSL by 0 -> result unchanged, C = 0.
- Lookup path: LUT[0x10] = 0xAB from LUT_FILE, ALUorM=1, MOV imm 0x10 into R2 -> Result = 0xAB and R2 = 0xAB. Flags come from 0x10, giving {0,0,0,0}.
- Reset asserted in the same cycle as WE=1 writing 0x55 -> register stays 0x00 and flags stay 0000. Execution after reset deasserts resumes normally.

Source files
------------

// File: rtl/datapath_unit.sv
// Execution datapath: 4-entry register file, 8-op ALU, read-only lookup memory
// and a registered NZCV flag register feeding the controller's branch logic.
module datapath_unit #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned LUT_DEPTH = 256,
  // Lookup memory image, entry i at bits [i*DATA_W +: DATA_W]; unlisted entries read 0.
  parameter logic [LUT_DEPTH*DATA_W-1:0] LUT_INIT = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              WE,
  input  logic              ALUorM,
  input  logic [2:0]        ALUCntr,
  input  logic              ALUSrc2,
  input  logic [1:0]        RDst3,
  input  logic [1:0]        RSrc1,
  input  logic [DATA_W-1:0] Src2,
  input  logic [1:0]        ViewSel,
  output logic [3:0]        ALUFlags,
  output logic [DATA_W-1:0] Result,
  output logic [DATA_W-1:0] RegView
);

  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned LUT_AW   = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LSL = 3'b101;
  localparam logic [2:0] OP_LSR = 3'b110;
  localparam logic [2:0] OP_MOV = 3'b111;

  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic [3:0]        flags_q;
  logic [3:0]        flags_d;

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic              alu_v;
  logic [DATA_W:0]   sum_w;
  logic [DATA_W:0]   diff_w;
  logic [DATA_W:0]   lsl_w;
  logic [DATA_W:0]   lsr_w;
  logic [2:0]        sh;

  logic [DATA_W-1:0] rom [LUT_DEPTH];
  logic              lut_hit;
  logic [DATA_W-1:0] lut_rd;

  // Operand fetch: register reads are combinational and see pre-edge contents.
  always_comb begin
    op_a = rf_q[RSrc1];
    op_b = ALUSrc2 ? Src2 : rf_q[Src2[1:0]];
  end

  // Extra bit on the shift vectors captures the last bit shifted out; it is 0 for a zero shift.
  always_comb begin
    sh     = op_b[2:0];
    sum_w  = {1'b0, op_a} + {1'b0, op_b};
    diff_w = {1'b0, op_a} - {1'b0, op_b};
    lsl_w  = {1'b0, op_a} << sh;
    lsr_w  = {op_a, 1'b0} >> sh;
  end

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (ALUCntr)
      OP_ADD: begin
        alu_res = sum_w[DATA_W-1:0];
        alu_c   = sum_w[DATA_W];
        alu_v   = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                  (sum_w[DATA_W-1] != op_a[DATA_W-1]);
      end
      OP_SUB: begin
        alu_res = diff_w[DATA_W-1:0];
        alu_c   = ~diff_w[DATA_W];
        alu_v   = (op_a[DATA_W-1] != op_b[DATA_W-1]) &&
                  (diff_w[DATA_W-1] != op_a[DATA_W-1]);
      end
      OP_AND: alu_res = op_a & op_b;
      OP_OR:  alu_res = op_a | op_b;
      OP_XOR: alu_res = op_a ^ op_b;
      OP_LSL: begin
        alu_res = lsl_w[DATA_W-1:0];
        alu_c   = lsl_w[DATA_W];
      end
      OP_LSR: begin
        alu_res = lsr_w[DATA_W:1];
        alu_c   = lsr_w[0];
      end
      OP_MOV: alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  // Lookup memory; addresses past the populated depth read 0.
  for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_rom
    assign rom[g] = LUT_INIT[g*DATA_W +: DATA_W];
  end

  always_comb begin
    lut_hit = (32'(alu_res) < LUT_DEPTH);
    lut_rd  = lut_hit ? rom[LUT_AW'(alu_res)] : '0;
  end

  always_comb begin
    Result  = ALUorM ? lut_rd : alu_res;
    RegView = rf_q[ViewSel];
    flags_d = {alu_res[DATA_W-1], (alu_res == '0), alu_c, alu_v};
  end

  // Flags track every executed instruction so WE=0 compares still set them.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (WE) begin
      rf_q[RDst3] <= Result;
    end
  end

  assign ALUFlags = flags_q;

endmodule

// File: tb/tb_datapath_unit.sv
// Directed, table-driven bench for datapath_unit with hand-computed expectations.
module tb_datapath_unit;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 256;
  localparam logic [DEPTH*DW-1:0] TB_LUT =
    (2048'(8'hAB) << (16 * 8)) | (2048'(8'hC3) << (2 * 8));

  logic          clk = 1'b0;
  logic          reset;
  logic          WE;
  logic          ALUorM;
  logic [2:0]    ALUCntr;
  logic          ALUSrc2;
  logic [1:0]    RDst3;
  logic [1:0]    RSrc1;
  logic [DW-1:0] Src2;
  logic [1:0]    ViewSel;
  logic [3:0]    ALUFlags;
  logic [DW-1:0] Result;
  logic [DW-1:0] RegView;

  int n_chk  = 0;
  int n_fail = 0;

  datapath_unit #(
    .DATA_W   (DW),
    .LUT_DEPTH(DEPTH),
    .LUT_INIT (TB_LUT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .WE      (WE),
    .ALUorM  (ALUorM),
    .ALUCntr (ALUCntr),
    .ALUSrc2 (ALUSrc2),
    .RDst3   (RDst3),
    .RSrc1   (RSrc1),
    .Src2    (Src2),
    .ViewSel (ViewSel),
    .ALUFlags(ALUFlags),
    .Result  (Result),
    .RegView (RegView)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic       m;
    logic [2:0] op;
    logic       imm;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [7:0] src2;
    logic [7:0] exp_res;
    logic [3:0] exp_flags;
    logic [1:0] view;
    logic [7:0] exp_view;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic m, input logic [2:0] op,
                              input logic imm, input logic [1:0] rd, input logic [1:0] rs1,
                              input logic [7:0] src2, input logic [7:0] exp_res,
                              input logic [3:0] exp_flags, input logic [1:0] view,
                              input logic [7:0] exp_view);
    vec_t v;
    v.we = we; v.m = m; v.op = op; v.imm = imm; v.rd = rd; v.rs1 = rs1;
    v.src2 = src2; v.exp_res = exp_res; v.exp_flags = exp_flags;
    v.view = view; v.exp_view = exp_view;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic we, input logic m, input logic [2:0] op,
                       input logic imm, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [7:0] src2);
    reset = rst; WE = we; ALUorM = m; ALUCntr = op; ALUSrc2 = imm;
    RDst3 = rd; RSrc1 = rs1; Src2 = src2;
  endtask

  // Result is checked before the edge, flags and destination register after it.
  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    drive(1'b0, v.we, v.m, v.op, v.imm, v.rd, v.rs1, v.src2);
    #1;
    chk($sformatf("v%0d_result", idx), Result, v.exp_res);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_flags", idx), 8'(ALUFlags), 8'(v.exp_flags));
    ViewSel = v.view;
    #1;
    chk($sformatf("v%0d_regview", idx), RegView, v.exp_view);
  endtask

  initial begin
    //              we    m     op      imm   rd     rs1    src2   res    flags    view   reg
    vecs.push_back(mk(1'b1, 1'b0, 3'b111, 1'b1, 2'd1, 2'd0, 8'h7F, 8'h7F, 4'b0000, 2'd1, 8'h7F));
    vecs.push_back(mk(1'b1, 1'b0, 3'b000, 1'b1, 2'd2, 2'd1, 8'h01, 8'h80, 4'b1001, 2'd2, 8'h80));
    vecs.push_back(mk(1'b1, 1'b0, 3'b111, 1'b1, 2'd1, 2'd0, 8'h05, 8'h05, 4'b0000, 2'd1, 8'h05));
    vecs.push_back(mk(1'b0, 1'b0, 3'b001, 1'b1, 2'd3, 2'd1, 8'h05, 8'h00, 4'b0110, 2'd3, 8'h00));
    vecs.push_back(mk(1'b0, 1'b0, 3'b001, 1'b1, 2'd1, 2'd1, 8'h06, 8'hFF, 4'b1000, 2'd1, 8'h05));
    vecs.push_back(mk(1'b1, 1'b0, 3'b111, 1'b1, 2'd0, 2'd0, 8'hFF, 8'hFF, 4'b1000, 2'd0, 8'hFF));
    vecs.push_back(mk(1'b1, 1'b0, 3'b000, 1'b1, 2'd0, 2'd0, 8'h01, 8'h00, 4'b0110, 2'd0, 8'h00));
    vecs.push_back(mk(1'b1, 1'b0, 3'b111, 1'b1, 2'd3, 2'd0, 8'h81, 8'h81, 4'b1000, 2'd3, 8'h81));
    vecs.push_back(mk(1'b1, 1'b0, 3'b101, 1'b1, 2'd0, 2'd3, 8'h01, 8'h02, 4'b0010, 2'd0, 8'h02));
    vecs.push_back(mk(1'b1, 1'b0, 3'b110, 1'b1, 2'd1, 2'd3, 8'h01, 8'h40, 4'b0010, 2'd1, 8'h40));
    vecs.push_back(mk(1'b1, 1'b0, 3'b101, 1'b1, 2'd2, 2'd3, 8'h00, 8'h81, 4'b1000, 2'd2, 8'h81));
    vecs.push_back(mk(1'b1, 1'b1, 3'b111, 1'b1, 2'd2, 2'd0, 8'h10, 8'hAB, 4'b0000, 2'd2, 8'hAB));
    vecs.push_back(mk(1'b1, 1'b0, 3'b000, 1'b0, 2'd1, 2'd3, 8'hFE, 8'h2C, 4'b0011, 2'd1, 8'h2C));
    vecs.push_back(mk(1'b1, 1'b0, 3'b010, 1'b1, 2'd0, 2'd1, 8'h0F, 8'h0C, 4'b0000, 2'd0, 8'h0C));
    vecs.push_back(mk(1'b1, 1'b0, 3'b011, 1'b0, 2'd0, 2'd0, 8'h03, 8'h8D, 4'b1000, 2'd0, 8'h8D));
    vecs.push_back(mk(1'b1, 1'b0, 3'b100, 1'b1, 2'd3, 2'd0, 8'h8D, 8'h00, 4'b0100, 2'd3, 8'h00));
    vecs.push_back(mk(1'b1, 1'b0, 3'b000, 1'b1, 2'd1, 2'd1, 8'h01, 8'h2D, 4'b0000, 2'd1, 8'h2D));
    vecs.push_back(mk(1'b0, 1'b0, 3'b001, 1'b1, 2'd0, 2'd2, 8'h7F, 8'h2C, 4'b0011, 2'd2, 8'hAB));
    vecs.push_back(mk(1'b1, 1'b0, 3'b110, 1'b1, 2'd3, 2'd2, 8'h0C, 8'h0A, 4'b0010, 2'd3, 8'h0A));
    vecs.push_back(mk(1'b1, 1'b1, 3'b111, 1'b1, 2'd0, 2'd0, 8'h02, 8'hC3, 4'b0000, 2'd0, 8'hC3));
    vecs.push_back(mk(1'b1, 1'b1, 3'b111, 1'b1, 2'd1, 2'd0, 8'h20, 8'h00, 4'b0000, 2'd1, 8'h00));
    vecs.push_back(mk(1'b1, 1'b0, 3'b111, 1'b1, 2'd3, 2'd0, 8'hFF, 8'hFF, 4'b1000, 2'd3, 8'hFF));

    ViewSel = 2'd0;
    drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 2'd0, 2'd0, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ViewSel = 2'(i);
      #1;
      chk($sformatf("reset_r%0d", i), RegView, 8'h00);
    end
    chk("reset_flags", 8'(ALUFlags), 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], i);
    end

    // Reset collides with a write of 0x55; reset must win and clear the flags.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 3'b111, 1'b1, 2'd0, 2'd0, 8'h55);
    @(posedge clk);
    #1;
    chk("rst_we_flags", 8'(ALUFlags), 8'h00);
    for (int i = 0; i < 4; i++) begin
      ViewSel = 2'(i);
      #1;
      chk($sformatf("rst_we_r%0d", i), RegView, 8'h00);
    end

    // Execution resumes after reset deasserts.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 3'b111, 1'b1, 2'd0, 2'd0, 8'h55);
    @(posedge clk);
    #1;
    ViewSel = 2'd0;
    #1;
    chk("resume_mov_r0", RegView, 8'h55);
    chk("resume_mov_flags", 8'(ALUFlags), 8'h00);

    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 2'd1, 2'd0, 8'h00);
    #1;
    chk("resume_add_result", Result, 8'hAA);
    @(posedge clk);
    #1;
    ViewSel = 2'd1;
    #1;
    chk("resume_add_r1", RegView, 8'hAA);
    chk("resume_add_flags", 8'(ALUFlags), 8'b0000_1001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
